// File: rtl/seg7_serial_scan_if.sv
// Pin and data bundle for the serial 7-segment scanner.
// Master drives digit data and masks; slave drives the 74HC595 pins.
interface seg7_serial_scan_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic [4*DIGITS-1:0]   digit_data;
  logic [DIGITS-1:0]     dp_mask;
  logic [DIGITS-1:0]     blank_mask;
  logic                  seg_ser;
  logic                  com_ser;
  logic                  srclk;
  logic                  seg_rclk;
  logic                  com_rclk;
  logic [5:0]            step;
  logic [3:0]            cur_nibble;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output enable, digit_data, dp_mask, blank_mask,
    input  seg_ser, com_ser, srclk, seg_rclk, com_rclk,
    input  step, cur_nibble, busy, frame_done
  );

  modport slave (
    input  enable, digit_data, dp_mask, blank_mask,
    output seg_ser, com_ser, srclk, seg_rclk, com_rclk,
    output step, cur_nibble, busy, frame_done
  );
endinterface

// File: rtl/seg7_serial_scan.sv
// Multiplexed 7-segment scanner driving two 74HC595 chains.
// One digit per pass: shift 8 bits, latch, hold, next digit.
module seg7_serial_scan #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 4,
  parameter int HOLD_TICKS     = 32,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit COM_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  seg7_serial_scan_if.slave bus
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(DIGITS - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH,
    HOLD
  } state_t;

  state_t              state;
  logic [DW-1:0]       div;
  logic [KW-1:0]       k;
  logic [HW-1:0]       hold_cnt;
  logic [4*DIGITS-1:0] fr_data;
  logic [DIGITS-1:0]   fr_dp;
  logic [DIGITS-1:0]   fr_blank;
  logic [7:0]          seg_byte;
  logic [7:0]          com_byte;
  logic [5:0]          step;
  logic                ser_s;
  logic                ser_c;
  logic                sclk;
  logic                rclk;
  logic [3:0]          nibble;
  logic                done;

  logic                tick;
  logic                last;
  logic                hold_end;
  logic                live;
  logic                go_load;
  logic [KW-1:0]       ld_k;
  logic [3:0]          ld_nib;
  logic                ld_dp;
  logic                ld_blank;
  logic [7:0]          ld_seg;
  logic [7:0]          ld_com;
  logic [2:0]          bit_idx;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    unique case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      4'hF: hex7 = 7'h71;
    endcase
  endfunction

  // A new frame (from IDLE or after the last digit) reads live inputs.
  always_comb begin
    tick     = (div == DIV_LAST);
    last     = (k == K_LAST);
    hold_end = (hold_cnt == H_LAST);
    live     = (state == IDLE) || last;
    go_load  = tick &&
               ((state == IDLE && bus.enable) ||
                (state == HOLD && hold_end &&
                 (!last || bus.enable)));
    ld_k     = live ? '0 : k + 1'b1;
    if (live) begin
      ld_nib   = bus.digit_data[3:0];
      ld_dp    = bus.dp_mask[0];
      ld_blank = bus.blank_mask[0];
    end else begin
      ld_nib   = fr_data[4*ld_k +: 4];
      ld_dp    = fr_dp[ld_k];
      ld_blank = fr_blank[ld_k];
    end
    ld_seg = ld_blank ? 8'h00 : {ld_dp, hex7(ld_nib)};
    ld_com = 8'h01 << ld_k;
    if (SEG_ACTIVE_LOW) ld_seg = ~ld_seg;
    if (COM_ACTIVE_LOW) ld_com = ~ld_com;
    bit_idx = ~(step[3:1] + 3'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div      <= '0;
      k        <= '0;
      hold_cnt <= '0;
      fr_data  <= '0;
      fr_dp    <= '0;
      fr_blank <= '0;
      seg_byte <= '0;
      com_byte <= '0;
      step     <= '0;
      ser_s    <= 1'b0;
      ser_c    <= 1'b0;
      sclk     <= 1'b0;
      rclk     <= 1'b0;
      nibble   <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      div  <= tick ? '0 : div + 1'b1;
      if (tick) begin
        unique case (state)
          IDLE: begin
          end
          SHIFT: begin
            if (step == 6'd15) begin
              state <= LATCH;
              step  <= 6'd16;
              sclk  <= 1'b0;
              rclk  <= 1'b1;
            end else begin
              step <= step + 6'd1;
              sclk <= ~step[0];
              if (step[0]) begin
                ser_s <= seg_byte[bit_idx];
                ser_c <= com_byte[bit_idx];
              end
            end
          end
          LATCH: begin
            if (step == 6'd16) begin
              step <= 6'd17;
              rclk <= 1'b0;
            end else begin
              state    <= HOLD;
              step     <= 6'd18;
              hold_cnt <= '0;
            end
          end
          HOLD: begin
            if (!hold_end) begin
              hold_cnt <= hold_cnt + 1'b1;
            end else if (last) begin
              done  <= 1'b1;
              state <= IDLE;
              step  <= '0;
              ser_s <= 1'b0;
              ser_c <= 1'b0;
            end
          end
          default: begin
          end
        endcase
        if (go_load) begin
          if (live) begin
            fr_data  <= bus.digit_data;
            fr_dp    <= bus.dp_mask;
            fr_blank <= bus.blank_mask;
          end
          state    <= SHIFT;
          k        <= ld_k;
          step     <= '0;
          seg_byte <= ld_seg;
          com_byte <= ld_com;
          ser_s    <= ld_seg[7];
          ser_c    <= ld_com[7];
          sclk     <= 1'b0;
          nibble   <= ld_nib;
        end
      end
    end
  end

  assign bus.seg_ser    = ser_s;
  assign bus.com_ser    = ser_c;
  assign bus.srclk      = sclk;
  assign bus.seg_rclk   = rclk;
  assign bus.com_rclk   = rclk;
  assign bus.step       = step;
  assign bus.cur_nibble = nibble;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = done;

endmodule

// File: tb/tb_seg7_serial_scan.sv
// Bench: two scanners (active-low and active-high) fed the same
// stimulus; 595 chains are deshifted and compared to a display model.
module tb_seg7_serial_scan;

  localparam int CLK_DIV = 4;
  localparam int HOLD    = 2;
  localparam int FRAME   = 4 * (18 + HOLD) * CLK_DIV;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] data   = 16'h0;
  logic [3:0]  dp     = 4'h0;
  logic [3:0]  bl     = 4'h0;

  always #5 clk = ~clk;

  seg7_serial_scan_if #(.DIGITS(4)) ifa ();
  seg7_serial_scan_if #(.DIGITS(4)) ifb ();

  assign ifa.enable     = enable;
  assign ifa.digit_data = data;
  assign ifa.dp_mask    = dp;
  assign ifa.blank_mask = bl;
  assign ifb.enable     = enable;
  assign ifb.digit_data = data;
  assign ifb.dp_mask    = dp;
  assign ifb.blank_mask = bl;

  seg7_serial_scan #(
    .DIGITS(4), .CLK_DIV(CLK_DIV), .HOLD_TICKS(HOLD),
    .SEG_ACTIVE_LOW(1'b1), .COM_ACTIVE_LOW(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
  );

  seg7_serial_scan #(
    .DIGITS(4), .CLK_DIV(CLK_DIV), .HOLD_TICKS(HOLD),
    .SEG_ACTIVE_LOW(1'b0), .COM_ACTIVE_LOW(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out or missing", nm);
  endtask

  // Display model: what a 595 pair must hold for one digit.
  localparam logic [7:0] HEX [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  function automatic logic [7:0] m_seg(input logic [3:0] n,
    input logic d, input logic b, input bit al);
    logic [7:0] v;
    v = b ? 8'h00 : (HEX[n] | (d ? 8'h80 : 8'h00));
    return al ? ~v : v;
  endfunction

  function automatic logic [7:0] m_com(input int k, input bit al);
    logic [7:0] v;
    v = 8'h01 << k;
    return al ? ~v : v;
  endfunction

  typedef struct packed {
    logic [7:0] seg;
    logic [7:0] com;
    logic [3:0] nib;
  } cap_t;

  cap_t       qa[$];
  cap_t       qb[$];
  int         fd_q[$];
  logic [7:0] sra = 8'h0, cra = 8'h0, srb = 8'h0, crb = 8'h0;

  always @(posedge ifa.srclk) begin
    sra = {sra[6:0], ifa.seg_ser};
    cra = {cra[6:0], ifa.com_ser};
  end
  always @(posedge ifb.srclk) begin
    srb = {srb[6:0], ifb.seg_ser};
    crb = {crb[6:0], ifb.com_ser};
  end
  always @(posedge ifa.seg_rclk) qa.push_back('{sra, cra, ifa.cur_nibble});
  always @(posedge ifb.seg_rclk) qb.push_back('{srb, crb, ifb.cur_nibble});

  logic pa_sc = 0, pa_ss = 0, pa_cs = 0, pa_fd = 0;
  logic pb_sc = 0, pb_ss = 0, pb_cs = 0, pb_fd = 0;

  task automatic cyc_chk(input string nm, input logic sc,
    input logic ss, input logic cs, input logic rs, input logic rc,
    input logic busy, input logic fd, input logic p_sc,
    input logic p_ss, input logic p_cs, input logic p_fd);
    chk({nm, "_rclk_eq"}, 32'(rs), 32'(rc));
    if (sc && !p_sc)
      chk({nm, "_ser_stable"}, 32'({ss, cs}), 32'({p_ss, p_cs}));
    if (!busy)
      chk({nm, "_idle_pins"}, 32'({ss, cs, sc, rs, rc}), 32'd0);
    if (fd)
      chk({nm, "_fd_width"}, 32'(p_fd), 32'd0);
  endtask

  always @(negedge clk) begin
    cyc_chk("a", ifa.srclk, ifa.seg_ser, ifa.com_ser, ifa.seg_rclk,
            ifa.com_rclk, ifa.busy, ifa.frame_done,
            pa_sc, pa_ss, pa_cs, pa_fd);
    cyc_chk("b", ifb.srclk, ifb.seg_ser, ifb.com_ser, ifb.seg_rclk,
            ifb.com_rclk, ifb.busy, ifb.frame_done,
            pb_sc, pb_ss, pb_cs, pb_fd);
    pa_sc = ifa.srclk;
    pa_ss = ifa.seg_ser;
    pa_cs = ifa.com_ser;
    pa_fd = ifa.frame_done;
    pb_sc = ifb.srclk;
    pb_ss = ifb.seg_ser;
    pb_cs = ifb.com_ser;
    pb_fd = ifb.frame_done;
    if (ifa.frame_done) fd_q.push_back(cyc);
  end

  task automatic wait_caps(input int n);
    int t = 0;
    while (qa.size() < n && t < 2 * FRAME) begin
      @(negedge clk);
      t++;
    end
    if (qa.size() < n) fail_now($sformatf("wait_caps_%0d", n));
  endtask

  task automatic wait_fd(input int n);
    int t = 0;
    while (fd_q.size() < n && t < 2 * FRAME) begin
      @(negedge clk);
      t++;
    end
    if (fd_q.size() < n) fail_now($sformatf("wait_fd_%0d", n));
  endtask

  task automatic wait_busy(output int at);
    int t = 0;
    while (!ifa.busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    at = cyc;
    if (!ifa.busy) fail_now("wait_busy");
  endtask

  task automatic check_frame(input int base, input logic [15:0] d,
    input logic [3:0] p, input logic [3:0] b);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] n;
      int i;
      n = d[4*k +: 4];
      i = base + k;
      if (qa.size() <= i || qb.size() <= i) begin
        fail_now($sformatf("capture_%0d", i));
      end else begin
        chk($sformatf("a%0d_seg", i), 32'(qa[i].seg),
            32'(m_seg(n, p[k], b[k], 1'b1)));
        chk($sformatf("a%0d_com", i), 32'(qa[i].com),
            32'(m_com(k, 1'b1)));
        chk($sformatf("a%0d_nib", i), 32'(qa[i].nib), 32'(n));
        chk($sformatf("b%0d_seg", i), 32'(qb[i].seg),
            32'(m_seg(n, p[k], b[k], 1'b0)));
        chk($sformatf("b%0d_com", i), 32'(qb[i].com),
            32'(m_com(k, 1'b0)));
      end
    end
  endtask

  task automatic lit(input bit use_b, input int i,
    input logic [7:0] seg, input logic [7:0] com);
    cap_t c;
    if ((use_b ? qb.size() : qa.size()) <= i) begin
      fail_now($sformatf("lit_capture_%0d", i));
    end else begin
      c = use_b ? qb[i] : qa[i];
      chk($sformatf("lit%s%0d_seg", use_b ? "b" : "a", i),
          32'(c.seg), 32'(seg));
      chk($sformatf("lit%s%0d_com", use_b ? "b" : "a", i),
          32'(c.com), 32'(com));
    end
  endtask

  function automatic logic [31:0] pins(input logic ss, input logic cs,
    input logic sc, input logic rs, input logic rc, input logic bz,
    input logic fd, input logic [5:0] st, input logic [3:0] nb);
    return 32'({ss, cs, sc, rs, rc, bz, fd, st, nb});
  endfunction

  logic [7:0] la_seg [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
  logic [7:0] la_com [4] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
  logic [7:0] lb_seg [4] = '{8'hB9, 8'h5E, 8'hF9, 8'h71};
  logic [7:0] lb_com [4] = '{8'h01, 8'h02, 8'h04, 8'h08};

  initial begin
    int rel, t0, t, t_end;
    data = 16'h3210;
    repeat (3) @(negedge clk);
    chk("a_reset", pins(ifa.seg_ser, ifa.com_ser, ifa.srclk,
        ifa.seg_rclk, ifa.com_rclk, ifa.busy, ifa.frame_done,
        ifa.step, ifa.cur_nibble), 32'd0);
    chk("b_reset", pins(ifb.seg_ser, ifb.com_ser, ifb.srclk,
        ifb.seg_rclk, ifb.com_rclk, ifb.busy, ifb.frame_done,
        ifb.step, ifb.cur_nibble), 32'd0);

    enable = 1'b1;
    rst_n  = 1'b1;
    rel    = cyc;
    wait_busy(t0);
    chk("first_tick", 32'(t0 - rel), 32'(CLK_DIV));
    chk("start_step", 32'(ifa.step), 32'd0);
    chk("start_msb_a", 32'(ifa.seg_ser), 32'd1);
    chk("start_msb_b", 32'(ifb.seg_ser), 32'd0);

    wait_caps(4);
    data = 16'hFEDC;
    dp   = 4'b0101;
    check_frame(0, 16'h3210, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) lit(1'b0, i, la_seg[i], la_com[i]);
    wait_fd(1);
    if (fd_q.size() > 0)
      chk("frame1_time", 32'(fd_q[0] - t0), 32'(FRAME));

    wait_caps(8);
    data = 16'h3210;
    dp   = 4'b1111;
    bl   = 4'b0010;
    check_frame(4, 16'hFEDC, 4'b0101, 4'h0);
    for (int i = 0; i < 4; i++) lit(1'b1, 4 + i, lb_seg[i], lb_com[i]);
    wait_fd(2);
    if (fd_q.size() > 1)
      chk("frame2_time", 32'(fd_q[1] - fd_q[0]), 32'(FRAME));

    wait_caps(12);
    data = 16'h1111;
    dp   = 4'h0;
    bl   = 4'h0;
    check_frame(8, 16'h3210, 4'b1111, 4'b0010);
    lit(1'b0, 8, 8'h40, 8'hFE);
    lit(1'b0, 9, 8'hFF, 8'hFD);

    wait_caps(14);
    data = 16'h2222;
    wait_caps(16);
    check_frame(12, 16'h1111, 4'h0, 4'h0);

    wait_caps(19);
    enable = 1'b0;
    wait_fd(5);
    check_frame(16, 16'h2222, 4'h0, 4'h0);
    repeat (CLK_DIV) @(negedge clk);
    chk("a_idle_after_drop", pins(ifa.seg_ser, ifa.com_ser, ifa.srclk,
        ifa.seg_rclk, ifa.com_rclk, ifa.busy, ifa.frame_done,
        6'd0, 4'd0), 32'd0);
    chk("b_idle_busy", 32'(ifb.busy), 32'd0);
    repeat (100) @(negedge clk);
    chk("no_more_caps", 32'(qa.size()), 32'd20);
    chk("no_more_frames", 32'(fd_q.size()), 32'd5);

    enable = 1'b1;
    t = 0;
    while (ifa.step != 6'd7 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (ifa.step != 6'd7) fail_now("reach_step7");
    t_end = qa.size();
    rst_n = 1'b0;
    #1;
    chk("a_async_reset", pins(ifa.seg_ser, ifa.com_ser, ifa.srclk,
        ifa.seg_rclk, ifa.com_rclk, ifa.busy, ifa.frame_done,
        ifa.step, ifa.cur_nibble), 32'd0);
    chk("b_async_reset", pins(ifb.seg_ser, ifb.com_ser, ifb.srclk,
        ifb.seg_rclk, ifb.com_rclk, ifb.busy, ifb.frame_done,
        ifb.step, ifb.cur_nibble), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rel   = cyc;
    wait_busy(t);
    chk("restart_tick", 32'(t - rel), 32'(CLK_DIV));
    chk("restart_step", 32'(ifa.step), 32'd0);
    chk("restart_nib", 32'(ifa.cur_nibble), 32'd2);
    wait_caps(t_end + 1);
    lit(1'b0, t_end, 8'hA4, 8'hFE);
    lit(1'b1, t_end, 8'h5B, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
